hartslag_meter: RTL and testbench
=================================

// Module: hartslag_meter
// PURPOSE
// - Heart-rate front end sitting directly upstream of the stress detector; it conditions the raw hartslagIngang pin.
// - It synchronises and debounces the pulse, then measures the beat-to-beat interval in slow ticks from clkDelay.
// - Outputs: a validated period, a high-rate (stress) flag with hysteresis, and a signal-lost flag for the stress/controller path.
// PARAMETERS
// - PERIOD_W    12    width of period counter/output (ticks)
// - DEB_TICKS   4     consecutive equal samples (on tick) needed to change debounced level
// - MIN_PERIOD  250   shorter intervals are artefacts (>240 bpm at 1 kHz tick), ignored
// - MAX_PERIOD  3000  interval timeout; counter saturates here, declares signal lost
// - STRESS_LO   500   period <= STRESS_LO sets stress_hoog (>=120 bpm at 1 kHz tick)
// - HYST        25    stress_hoog clears only when period >= STRESS_LO+HYST
// PORTS
// - clk           in   1         system clock
// - reset         in   1         synchronous, active-high reset
// - tick          in   1         one-clk enable pulse from clkDelay (slow)
// - hartslag_in   in   1         raw asynchronous heartbeat pulse
// - period        out  PERIOD_W  last accepted (or averaged) beat interval, ticks
// - period_valid  out  1         one-clk pulse when period updates
// - stress_hoog   out  1         high heart rate flag (level)
// - geen_signaal  out  1         no valid beat within MAX_PERIOD ticks (level)
// BEHAVIOUR
// - Reset: period=0, period_valid=0, stress_hoog=0, geen_signaal=0, state=WAIT_FIRST, counters=0, sync/debounce=0.
// - Sync: 2-FF synchroniser on every clk. Debounce: sampled only on tick; level flips after DEB_TICKS equal samples.
// - Edge: rising edge of debounced level, evaluated in the tick cycle; all state updates only in tick cycles.
// - interval count: +1 per tick, saturates at MAX_PERIOD, never wraps.
// - FSM WAIT_FIRST: first edge -> count=0, go MEASURE; no period emitted.
// - FSM MEASURE, edge with count < MIN_PERIOD: edge ignored, count keeps running.
// - FSM MEASURE, edge with MIN_PERIOD <= count < MAX_PERIOD: latch count into period.
//   - period_valid high the next clk for exactly 1 clk; count=0.
// - FSM MEASURE, count reaches MAX_PERIOD with no edge in that tick: geen_signaal=1, stress_hoog=0, go LOST.
// - Simultaneous edge and count==MAX_PERIOD-1 on same tick: the edge wins, period=MAX_PERIOD-1 accepted.
// - FSM LOST: next edge -> count=0, geen_signaal=0, go MEASURE; behaves like the first edge, no period emitted.
// - stress_hoog: evaluated on each period update.
//   - Set if period <= STRESS_LO; cleared if period >= STRESS_LO+HYST; otherwise held.
// - period holds its value across LOST; only period_valid signals new data.
// - Latency: debounced rising edge in tick cycle N -> period/period_valid/stress_hoog valid at N+1.
// - Reset asserted mid-measurement: everything returns to reset values in the next clk; no partial period emitted.
// CONFIGURATION
// - Macro HARTSLAG_AVG_EN defined: 4-entry history of accepted periods; period = (sum of 4) >> 2, sum width PERIOD_W+2.
//   - The first accepted period after reset/LOST pre-fills all 4 entries.
//   - stress_hoog compares the averaged value; latency unchanged, N+1.
// - Macro not defined: period = raw accepted interval; no history registers.
// STRUCTURE
// - Package hartslag_pkg: FSM state typedef {WAIT_FIRST, MEASURE, LOST}, default thresholds, AVG_DEPTH=4.
// - Sub-module hartslag_debounce: sync + tick-based debounce + rising-edge pulse; FSM/measure/compare stay in top.
// TESTING
// - Bench: tick every 4 clk, defaults.
// - Reset, 20 ticks idle -> all outputs 0, no period_valid.
// - Clean beats every 600 ticks -> first beat gives no output; then period=600, 1-clk period_valid per beat, stress_hoog=0.
// - Intervals 600, 480, 510, 530: stress_hoog sets at 480, holds at 510 (<525), clears at 530.
// - 200-tick glitch between 600-tick beats -> glitch ignored, period=600.
//   - A 2-tick-wide pulse never passes the debounce.
// - No beat for 3000 ticks -> geen_signaal=1, stress_hoog=0.
//   - Next beat clears geen_signaal, no period_valid; the following beat at 600 gives period=600.
// - With HARTSLAG_AVG_EN: beats at 600, 600, 600, 400 -> period 600, 600, 600, 550.
// - Assert reset mid-interval at count 300 -> outputs 0; next edge treated as first, no period.

Source files
------------

// File: rtl/hartslag_pkg.sv
// Shared constants, FSM state encoding and the stress hysteresis rule for the heartbeat meter.
package hartslag_pkg;

  localparam int DEF_PERIOD_W   = 12;
  localparam int DEF_DEB_TICKS  = 4;
  localparam int DEF_MIN_PERIOD = 250;
  localparam int DEF_MAX_PERIOD = 3000;
  localparam int DEF_STRESS_LO  = 500;
  localparam int DEF_HYST       = 25;
  localparam int AVG_DEPTH      = 4;

  typedef logic [1:0] state_t;
  localparam state_t WAIT_FIRST = 2'd0;
  localparam state_t MEASURE    = 2'd1;
  localparam state_t LOST       = 2'd2;

  // Between lo and lo+hyst the previous flag is kept.
  function automatic logic stress_eval(input int unsigned p, input int unsigned lo,
                                       input int unsigned hyst, input logic cur);
    if (p <= lo) return 1'b1;
    if (p >= lo + hyst) return 1'b0;
    return cur;
  endfunction

endpackage

// File: rtl/hartslag_debounce.sv
// 2-FF synchroniser plus tick-sampled debounce of the raw heartbeat pin.
// rise_o is combinational and only ever high in the tick cycle where the debounced level goes 0->1.
module hartslag_debounce #(
  parameter int DEB_TICKS = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic tick_i,
  input  logic din_i,
  output logic level_o,
  output logic rise_o
);

  localparam int CW = $clog2(DEB_TICKS + 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rise;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    if (tick_i) begin
      if (sync2_q != level_q) begin
        // cnt_q counts earlier differing samples; this one completes the run
        if (cnt_q == CW'(DEB_TICKS - 1)) begin
          level_d = sync2_q;
          cnt_d   = '0;
          rise    = sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise;

endmodule

// File: rtl/hartslag_meter.sv
// Beat-to-beat interval meter with stress hysteresis and signal-lost detection.
// HARTSLAG_AVG_EN: report the mean of the last 4 accepted intervals instead of the raw one.
module hartslag_meter
  import hartslag_pkg::*;
#(
  parameter int PERIOD_W   = DEF_PERIOD_W,
  parameter int DEB_TICKS  = DEF_DEB_TICKS,
  parameter int MIN_PERIOD = DEF_MIN_PERIOD,
  parameter int MAX_PERIOD = DEF_MAX_PERIOD,
  parameter int STRESS_LO  = DEF_STRESS_LO,
  parameter int HYST       = DEF_HYST
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                hartslag_in,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                stress_hoog,
  output logic                geen_signaal
);

  localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W-1:0] MAX_P = PERIOD_W'(MAX_PERIOD);

  logic                beat_rise;
  logic                beat_level;
  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] count_q, count_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                period_valid_q, period_valid_d;
  logic                stress_q, stress_d;
  logic                geen_q, geen_d;
  logic [PERIOD_W-1:0] cnt_inc;
  logic [PERIOD_W-1:0] new_period;
  logic                accept;
  logic                go_lost;

  hartslag_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
    .clk    (clk),
    .reset  (reset),
    .tick_i (tick),
    .din_i  (hartslag_in),
    .level_o(beat_level),
    .rise_o (beat_rise)
  );

  // cnt_inc is the number of ticks elapsed since the last accepted edge, including this one
  assign cnt_inc = (count_q >= MAX_P) ? MAX_P : count_q + 1'b1;
  assign accept  = tick && beat_rise && (state_q == MEASURE) &&
                   (cnt_inc >= MIN_P) && (cnt_inc < MAX_P);
  assign go_lost = tick && (state_q == MEASURE) && !accept && (cnt_inc == MAX_P);

`ifdef HARTSLAG_AVG_EN
  logic [PERIOD_W-1:0] hist_q [AVG_DEPTH];
  logic [PERIOD_W-1:0] hist_d [AVG_DEPTH];
  logic                hist_vld_q, hist_vld_d;
  logic [PERIOD_W+1:0] sum;

  always_comb begin
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    // An empty history behaves as if pre-filled with the current interval
    if (hist_vld_q)
      sum = {2'b00, cnt_inc} + {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]};
    else
      sum = {cnt_inc, 2'b00};
    if (accept) begin
      hist_vld_d = 1'b1;
      hist_d[0]  = cnt_inc;
      for (int i = 1; i < AVG_DEPTH; i++)
        hist_d[i] = hist_vld_q ? hist_q[i-1] : cnt_inc;
    end
    if (go_lost) hist_vld_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist_vld_q <= 1'b0;
      for (int i = 0; i < AVG_DEPTH; i++) hist_q[i] <= '0;
    end else begin
      hist_vld_q <= hist_vld_d;
      for (int i = 0; i < AVG_DEPTH; i++) hist_q[i] <= hist_d[i];
    end
  end

  assign new_period = sum[PERIOD_W+1:2];
`else
  assign new_period = cnt_inc;
`endif

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    stress_d       = stress_q;
    geen_d         = geen_q;
    if (tick) begin
      case (state_q)
        WAIT_FIRST: begin
          if (beat_rise) begin
            count_d = '0;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          if (accept) begin
            period_d       = new_period;
            period_valid_d = 1'b1;
            stress_d       = stress_eval(32'(new_period), STRESS_LO, HYST, stress_q);
            count_d        = '0;
          end else if (go_lost) begin
            count_d  = cnt_inc;
            geen_d   = 1'b1;
            stress_d = 1'b0;
            state_d  = LOST;
          end else begin
            count_d = cnt_inc;
          end
        end
        LOST: begin
          if (beat_rise) begin
            count_d = '0;
            geen_d  = 1'b0;
            state_d = MEASURE;
          end
        end
        default: state_d = WAIT_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= WAIT_FIRST;
      count_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      stress_q       <= 1'b0;
      geen_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      stress_q       <= stress_d;
      geen_q         <= geen_d;
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign stress_hoog  = stress_q;
  assign geen_signaal = geen_q;

endmodule

// File: tb/tb_hartslag_meter.sv
// Directed plus randomized bench for hartslag_meter against an interval-based reference model.
module tb_hartslag_meter;

  localparam int MIN = 250;
  localparam int MAX = 3000;
  localparam int LO  = 500;
  localparam int HY  = 25;
`ifdef HARTSLAG_AVG_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        tick;
  logic        hartslag_in;
  logic [11:0] period;
  logic        period_valid;
  logic        stress_hoog;
  logic        geen_signaal;

  hartslag_meter dut (
    .clk         (clk),
    .reset       (reset),
    .tick        (tick),
    .hartslag_in (hartslag_in),
    .period      (period),
    .period_valid(period_valid),
    .stress_hoog (stress_hoog),
    .geen_signaal(geen_signaal)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int tick_no = 0;

  // Reference model: times are tick indices of debounced edges
  bit m_first;
  int m_last;
  int m_period;
  bit m_stress;
  bit m_geen;
  int m_vld = 0;
  int hist[$];

  // Monitor: counts valid cycles and any valid lasting more than one clk
  int vld_cnt = 0;
  int wide_cnt = 0;
  bit prev_vld = 1'b0;
  always @(negedge clk) begin
    if (period_valid === 1'b1) begin
      vld_cnt++;
      if (prev_vld) wide_cnt++;
    end
    prev_vld = (period_valid === 1'b1);
  end

  function automatic void m_reset();
    m_first  = 1'b1;
    m_last   = 0;
    m_period = 0;
    m_stress = 1'b0;
    m_geen   = 1'b0;
    hist.delete();
  endfunction

  function automatic void m_settle(input int now);
    if (!m_first && (now - m_last) >= MAX) begin
      m_first  = 1'b1;
      m_geen   = 1'b1;
      m_stress = 1'b0;
      hist.delete();
    end
  endfunction

  function automatic bit m_edge(input int t);
    int iv;
    int s;
    if (!m_first && (t - m_last) == MAX) begin
      m_settle(t);
      return 1'b0;
    end
    m_settle(t);
    if (m_first) begin
      m_first = 1'b0;
      m_geen  = 1'b0;
      m_last  = t;
      return 1'b0;
    end
    iv = t - m_last;
    if (iv < MIN) return 1'b0;
    m_last = t;
    if (AVG) begin
      if (hist.size() == 0) begin
        for (int k = 0; k < 4; k++) hist.push_back(iv);
      end else begin
        hist.push_front(iv);
        void'(hist.pop_back());
      end
      s = 0;
      foreach (hist[k]) s += hist[k];
      m_period = s / 4;
    end else begin
      m_period = iv;
    end
    if (m_period <= LO) m_stress = 1'b1;
    else if (m_period >= LO + HY) m_stress = 1'b0;
    m_vld++;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv)
    else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step_tick();
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    tick_no++;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_period"}, 32'(period), m_period);
    chk({tag, "_stress"}, 32'(stress_hoog), 32'(m_stress));
    chk({tag, "_geen"}, 32'(geen_signaal), 32'(m_geen));
    chk({tag, "_vldcnt"}, vld_cnt, m_vld);
  endtask

  // Pin high for `width` ticks; next pulse starts `total` ticks after this one.
  task automatic pulse(input int width, input int total);
    bit exp_new;
    hartslag_in = 1'b1;
    exp_new = (width >= 4) ? m_edge(tick_no + 4) : 1'b0;
    for (int i = 1; i <= total; i++) begin
      step_tick();
      if (i == width) hartslag_in = 1'b0;
      if (i == 4) begin
        chk("lat_vld", 32'(period_valid), 32'(exp_new));
        if (exp_new) begin
          chk("lat_period", 32'(period), m_period);
          chk("lat_stress", 32'(stress_hoog), 32'(m_stress));
        end
      end
      if (i == 8) chk_state("beat");
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hartslag_in = 1'b0;
    step_tick();
    reset = 1'b0;
    m_reset();
  endtask

  initial begin
    int g1, g2, w;
    tick = 1'b0;
    hartslag_in = 1'b0;
    m_reset();
    do_reset();
    step_tick();
    chk_state("reset");
    chk("reset_vld", 32'(period_valid), 0);
    repeat (20) step_tick();
    chk_state("idle");

    // Clean 600-tick beats, then the hysteresis walk 480/510/530
    pulse(10, 600);
    pulse(10, 600);
    pulse(10, 480);
    pulse(10, 510);
    pulse(10, 530);
    pulse(10, 200);
    // Glitch at 200 ticks must be ignored, next real beat still 600 after the last one
    pulse(10, 400);
    pulse(10, 300);
    pulse(2, 300);
    pulse(10, 480);
    // Beat closing a 480 interval sets stress, then silence longer than MAX
    pulse(10, 3100);
    m_settle(tick_no);
    chk_state("lost");
    chk("lost_geen", 32'(geen_signaal), 1);
    pulse(10, 600);
    pulse(10, 600);
    // Reset 300 ticks into an interval
    pulse(10, 300);
    do_reset();
    chk_state("midrst");
    pulse(10, 600);
    pulse(10, 600);
    pulse(10, 600);
    pulse(10, 400);
    pulse(10, 300);

    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        g1 = $urandom_range(20, 200);
        g2 = $urandom_range(260, 450);
        w  = ($urandom_range(0, 1) == 0) ? 2 : 10;
        pulse(10, g1);
        pulse(w, g2);
      end else begin
        pulse(10, $urandom_range(260, 500));
      end
    end
    pulse(10, 20);

    chk("vld_width", wide_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
